// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run controller: panel modes, FSM states, widths.
package run_ctrl_pkg;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned COUNT_W = 16;
    localparam logic [2:0]  PHASE_LAST = 3'd7;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_PULSE  = 2'd1,
        MODE_INSN   = 2'd2,
        MODE_CONT   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

endpackage

// File: rtl/run_ctrl_bkpt_cmp.sv
// Breakpoint address comparator; only built when RUN_CTRL_BREAKPOINT_EN is defined.
`ifdef RUN_CTRL_BREAKPOINT_EN
module bkpt_cmp
    import run_ctrl_pkg::*;
(
    input  logic [ADDR_W-1:0] strt_addr,
    input  logic [ADDR_W-1:0] bkpt_addr,
    input  logic              bkpt_en,
    input  logic              exempt,
    output logic              hit
);

    assign hit = bkpt_en && !exempt && (strt_addr == bkpt_addr);

endmodule
`endif

// File: rtl/run_ctrl.sv
// Run controller: issues pulse-distributor start pulses under panel mode/run/stop/clear.
// Optional breakpoint stop is built when RUN_CTRL_BREAKPOINT_EN is defined.
module run_ctrl
    import run_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic [1:0]         mode_from_pnl,
    input  logic               run_pulse_from_pnl,
    input  logic               stop_pulse_from_pnl,
    input  logic               clear_pulse_from_pnl,
    input  logic [2:0]         pu_state_from_pu,
    input  logic               halt_from_op,
    input  logic               io_busy_from_io,
    input  logic [ADDR_W-1:0]  strt_addr_from_strt,
    input  logic [ADDR_W-1:0]  bkpt_addr_from_pnl,
    input  logic               bkpt_en_from_pnl,
    output logic               start_pulse_to_pu,
    output logic               clear_pu_to_pu,
    output logic               running_to_pnl,
    output logic               halted_to_pnl,
    output logic               bkpt_hit_to_pnl,
    output logic [COUNT_W-1:0] insn_count_to_pnl
);

    state_t     state, state_nxt;
    mode_t      mode;
    logic [2:0] latched_pu, latched_pu_nxt;
    logic [2:0] prev_pu;
    logic       pending_stop, pending_stop_nxt;
    logic       left_zero, left_zero_nxt;
    logic       halted_nxt, bkpt_hit_nxt, start_nxt;
    logic       pu_zero, halt_at_end, stop_now, step_stop, bkpt_match;

    assign mode        = mode_t'(mode_from_pnl);
    assign pu_zero     = (pu_state_from_pu == 3'd0);
    assign halt_at_end = halt_from_op && (pu_state_from_pu == PHASE_LAST);
    assign stop_now    = pending_stop || stop_pulse_from_pnl;
    assign step_stop   = (mode == MODE_PULSE) && stop_pulse_from_pnl;
    assign running_to_pnl = (state != ST_IDLE);

`ifdef RUN_CTRL_BREAKPOINT_EN
    // left_zero is still low for the instruction started by the run pulse, exempting it
    bkpt_cmp u_bkpt_cmp (
        .strt_addr (strt_addr_from_strt),
        .bkpt_addr (bkpt_addr_from_pnl),
        .bkpt_en   (bkpt_en_from_pnl),
        .exempt    (!left_zero),
        .hit       (bkpt_match)
    );
`else
    logic unused_bkpt;
    assign unused_bkpt = ^{strt_addr_from_strt, bkpt_addr_from_pnl, bkpt_en_from_pnl};
    assign bkpt_match  = 1'b0;
`endif

    always_comb begin
        state_nxt        = state;
        latched_pu_nxt   = latched_pu;
        pending_stop_nxt = pending_stop;
        left_zero_nxt    = left_zero;
        halted_nxt       = halted_to_pnl;
        bkpt_hit_nxt     = bkpt_hit_to_pnl;
        start_nxt        = 1'b0;

        if (state != ST_IDLE) begin
            if (!pu_zero) left_zero_nxt = 1'b1;
            if (stop_pulse_from_pnl || halt_at_end) pending_stop_nxt = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (run_pulse_from_pnl && mode != MODE_MANUAL) begin
                    state_nxt        = ST_ISSUE;
                    halted_nxt       = 1'b0;
                    bkpt_hit_nxt     = 1'b0;
                    left_zero_nxt    = 1'b0;
                    pending_stop_nxt = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (step_stop && !pu_zero) begin
                    state_nxt = ST_STOPPING;
                end else if (pu_zero && stop_now) begin
                    state_nxt        = ST_IDLE;
                    halted_nxt       = 1'b1;
                    pending_stop_nxt = 1'b0;
                end else if (pu_zero && mode == MODE_INSN && left_zero) begin
                    state_nxt = ST_IDLE;
                end else if (pu_zero && bkpt_match) begin
                    state_nxt    = ST_IDLE;
                    halted_nxt   = 1'b1;
                    bkpt_hit_nxt = 1'b1;
                end else if (!pu_state_from_pu[0] && !io_busy_from_io) begin
                    start_nxt      = 1'b1;
                    latched_pu_nxt = pu_state_from_pu;
                    state_nxt      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (step_stop && !pu_zero) begin
                    state_nxt = ST_STOPPING;
                end else if (step_stop) begin
                    state_nxt        = ST_IDLE;
                    halted_nxt       = 1'b1;
                    pending_stop_nxt = 1'b0;
                end else if (pu_state_from_pu != latched_pu) begin
                    state_nxt = (mode == MODE_PULSE) ? ST_IDLE : ST_ISSUE;
                end
            end
            ST_STOPPING: begin
                if (pu_zero) begin
                    state_nxt        = ST_IDLE;
                    halted_nxt       = 1'b1;
                    pending_stop_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Clear wins over run/stop and any pulse decided above.
        if (clear_pulse_from_pnl) begin
            state_nxt        = ST_IDLE;
            pending_stop_nxt = 1'b0;
            start_nxt        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state             <= ST_IDLE;
            latched_pu        <= '0;
            prev_pu           <= '0;
            pending_stop      <= 1'b0;
            left_zero         <= 1'b0;
            start_pulse_to_pu <= 1'b0;
            clear_pu_to_pu    <= 1'b0;
            halted_to_pnl     <= 1'b0;
            bkpt_hit_to_pnl   <= 1'b0;
            insn_count_to_pnl <= '0;
        end else begin
            state             <= state_nxt;
            latched_pu        <= latched_pu_nxt;
            prev_pu           <= pu_state_from_pu;
            pending_stop      <= pending_stop_nxt;
            left_zero         <= left_zero_nxt;
            start_pulse_to_pu <= start_nxt;
            clear_pu_to_pu    <= clear_pulse_from_pnl;
            halted_to_pnl     <= halted_nxt;
            bkpt_hit_to_pnl   <= bkpt_hit_nxt;
            if (prev_pu == PHASE_LAST && pu_zero)
                insn_count_to_pnl <= insn_count_to_pnl + COUNT_W'(1);
        end
    end

endmodule
